// File: rtl/painterengine_gpu_write_fifo_pkg.sv
// rtl/painterengine_gpu_write_fifo_pkg.sv - shared defaults for the GPU DMA writer staging FIFOs
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 64
`endif

package painterengine_gpu_write_fifo_pkg;

    localparam int FIFO_DEPTH_DEFAULT      = `FIFO_DEPTH;
    localparam int FIFO_DATA_WIDTH_DEFAULT = 32;
    localparam int FIFO_ALMOST_FULL_DEFAULT = 56;

    // Blocked-push cycles tolerated before a stall is reported; the DMA writer uses the same limit.
    localparam int STALL_TIMEOUT = 65535;

endpackage

// File: rtl/painterengine_gpu_fifo_ram.sv
// rtl/painterengine_gpu_fifo_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
module painterengine_gpu_fifo_ram #(
    parameter int PARAM_ENTRIES    = 63,
    parameter int PARAM_ADDR_WIDTH = 6,
    parameter int PARAM_DATA_WIDTH = 32
) (
    input  logic                        i_wire_clock,
    input  logic                        wr_en,
    input  logic [PARAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [PARAM_DATA_WIDTH-1:0] wr_data,
    input  logic [PARAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [PARAM_DATA_WIDTH-1:0] rd_data
);

    logic [PARAM_DATA_WIDTH-1:0] mem [0:PARAM_ENTRIES-1];

    always_ff @(posedge i_wire_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/painterengine_gpu_write_fifo.sv
// rtl/painterengine_gpu_write_fifo.sv - FWFT staging FIFO feeding one DMA writer router lane
module painterengine_gpu_write_fifo
    import painterengine_gpu_write_fifo_pkg::*;
#(
    parameter int PARAM_DEPTH       = FIFO_DEPTH_DEFAULT,
    parameter int PARAM_DATA_WIDTH  = FIFO_DATA_WIDTH_DEFAULT,
    parameter int PARAM_ALMOST_FULL = FIFO_ALMOST_FULL_DEFAULT
) (
    input  logic                             i_wire_clock,
    input  logic                             i_wire_resetn,
    input  logic                             i_wire_flush,
    input  logic [PARAM_DATA_WIDTH-1:0]      i_wire_push_data,
    input  logic                             i_wire_push_valid,
    output logic                             o_wire_push_ready,
    output logic [PARAM_DATA_WIDTH-1:0]      o_wire_data,
    output logic                             o_wire_data_valid,
    input  logic                             i_wire_data_next,
    output logic [$clog2(PARAM_DEPTH):0]     o_wire_level,
    output logic                             o_wire_almost_full,
    output logic [31:0]                      o_wire_popped_count,
    output logic                             o_wire_error
);

    localparam int PTR_WIDTH   = $clog2(PARAM_DEPTH);
    localparam int LVL_WIDTH   = PTR_WIDTH + 1;
    localparam int RAM_ENTRIES = PARAM_DEPTH - 1;

    logic [PTR_WIDTH-1:0]        wr_ptr;
    logic [PTR_WIDTH-1:0]        rd_ptr;
    logic [LVL_WIDTH-1:0]        level;
    logic [15:0]                 stall_cnt;
    logic [PARAM_DATA_WIDTH-1:0] ram_rd_data;

    logic push;
    logic pop;
    logic refill;
    logic ram_nonempty;
    logic bypass;
    logic ram_wr_en;

    // RAM depth is DEPTH-1, so wrap must be an explicit compare rather than overflow.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(RAM_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_wire_level       = level;
    assign o_wire_push_ready  = (level < LVL_WIDTH'(PARAM_DEPTH));
    assign o_wire_almost_full = (level >= LVL_WIDTH'(PARAM_ALMOST_FULL));

    assign push   = i_wire_push_valid && o_wire_push_ready;
    assign pop    = i_wire_data_next && o_wire_data_valid;
    assign refill = !o_wire_data_valid || pop;

    // The head is refilled whenever it empties, so RAM words exist only while the head is valid.
    assign ram_nonempty = (level > LVL_WIDTH'(1));
    assign bypass       = refill && !ram_nonempty && push;
    assign ram_wr_en    = push && !bypass && !i_wire_flush;

    painterengine_gpu_fifo_ram #(
        .PARAM_ENTRIES    (RAM_ENTRIES),
        .PARAM_ADDR_WIDTH (PTR_WIDTH),
        .PARAM_DATA_WIDTH (PARAM_DATA_WIDTH)
    ) u_ram (
        .i_wire_clock (i_wire_clock),
        .wr_en        (ram_wr_en),
        .wr_addr      (wr_ptr),
        .wr_data      (i_wire_push_data),
        .rd_addr      (rd_ptr),
        .rd_data      (ram_rd_data)
    );

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            level               <= '0;
            stall_cnt           <= '0;
            o_wire_data         <= '0;
            o_wire_data_valid   <= 1'b0;
            o_wire_popped_count <= '0;
            o_wire_error        <= 1'b0;
        end else if (i_wire_flush) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            level               <= '0;
            stall_cnt           <= '0;
            o_wire_data_valid   <= 1'b0;
            o_wire_popped_count <= '0;
            o_wire_error        <= 1'b0;
        end else begin
            if (refill) begin
                if (ram_nonempty) begin
                    o_wire_data       <= ram_rd_data;
                    o_wire_data_valid <= 1'b1;
                    rd_ptr            <= ptr_inc(rd_ptr);
                end else if (push) begin
                    o_wire_data       <= i_wire_push_data;
                    o_wire_data_valid <= 1'b1;
                end else begin
                    o_wire_data_valid <= 1'b0;
                end
            end

            if (ram_wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end

            level <= level + LVL_WIDTH'(push) - LVL_WIDTH'(pop);

            if (pop) begin
                o_wire_popped_count <= o_wire_popped_count + 32'd1;
            end

            if (i_wire_data_next && !o_wire_data_valid) begin
                o_wire_error <= 1'b1;
            end

            if (i_wire_push_valid && !o_wire_push_ready) begin
                if (stall_cnt == 16'(STALL_TIMEOUT)) begin
                    o_wire_error <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + 16'd1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_write_fifo.sv
// tb/tb_painterengine_gpu_write_fifo.sv - directed self-checking bench for the GPU write FIFO
module tb_painterengine_gpu_write_fifo;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] data;
    logic        data_valid;
    logic        data_next = 1'b0;
    logic [6:0]  level;
    logic        almost_full;
    logic [31:0] popped_count;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    painterengine_gpu_write_fifo dut (
        .i_wire_clock        (clk),
        .i_wire_resetn       (resetn),
        .i_wire_flush        (flush),
        .i_wire_push_data    (push_data),
        .i_wire_push_valid   (push_valid),
        .o_wire_push_ready   (push_ready),
        .o_wire_data         (data),
        .o_wire_data_valid   (data_valid),
        .i_wire_data_next    (data_next),
        .o_wire_level        (level),
        .o_wire_almost_full  (almost_full),
        .o_wire_popped_count (popped_count),
        .o_wire_error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_ready", 64'(push_ready), 64'd1);
        check("rst_level", 64'(level), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_popped", 64'(popped_count), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        step();
        resetn = 1'b1;
        step();

        // Empty bypass: one-cycle latency
        push_data = 32'hA5A5_0001;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        check("byp_valid", 64'(data_valid), 64'd1);
        check("byp_data", 64'(data), 64'hA5A5_0001);
        check("byp_level", 64'(level), 64'd1);
        data_next = 1'b1;
        step();
        data_next = 1'b0;
        check("byp_pop_valid", 64'(data_valid), 64'd0);
        check("byp_pop_level", 64'(level), 64'd0);
        check("byp_pop_count", 64'(popped_count), 64'd1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 64'(popped_count), 64'd0);

        // Fill to full with words 0..63
        for (int i = 0; i < 64; i++) begin
            push_data = 32'(i);
            push_valid = 1'b1;
            step();
            check("fill_level", 64'(level), 64'(i + 1));
            check("fill_af", 64'(almost_full), 64'((i + 1) >= 56));
        end
        check("full_ready", 64'(push_ready), 64'd0);
        check("full_head", 64'(data), 64'd0);

        // Held push while full is not accepted
        push_data = 32'd64;
        step();
        check("full_hold_level", 64'(level), 64'd64);

        // Simultaneous push and pop at full: only the pop happens
        data_next = 1'b1;
        step();
        data_next = 1'b0;
        check("simul_level", 64'(level), 64'd63);
        check("simul_head", 64'(data), 64'd1);
        step();
        push_valid = 1'b0;
        check("simul_retry_level", 64'(level), 64'd64);
        check("simul_retry_ready", 64'(push_ready), 64'd0);

        // Drain: 1..64 in order, exercising read-pointer wrap
        for (int i = 1; i <= 64; i++) begin
            check("drain_valid", 64'(data_valid), 64'd1);
            check("drain_data", 64'(data), 64'(i));
            data_next = 1'b1;
            step();
        end
        data_next = 1'b0;
        check("drain_level", 64'(level), 64'd0);
        check("drain_valid_end", 64'(data_valid), 64'd0);
        check("drain_count", 64'(popped_count), 64'd65);
        check("drain_error", 64'(error), 64'd0);

        // Streaming 200 words: push and pop every cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_data = 32'h1000_0000;
        push_valid = 1'b1;
        step();
        for (int i = 1; i < 200; i++) begin
            push_data = 32'h1000_0000 + 32'(i);
            data_next = 1'b1;
            check("stream_data", 64'(data), 64'(32'h1000_0000 + 32'(i - 1)));
            step();
            check("stream_level", 64'(level), 64'd1);
        end
        push_valid = 1'b0;
        check("stream_last", 64'(data), 64'h1000_00C7);
        step();
        data_next = 1'b0;
        check("stream_count", 64'(popped_count), 64'd200);
        check("stream_level_end", 64'(level), 64'd0);
        check("stream_error", 64'(error), 64'd0);

        // Underflow is sticky until flush
        data_next = 1'b1;
        step();
        data_next = 1'b0;
        check("uflow_error", 64'(error), 64'd1);
        check("uflow_level", 64'(level), 64'd0);
        check("uflow_count", 64'(popped_count), 64'd200);
        step();
        check("uflow_sticky", 64'(error), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("uflow_flush_err", 64'(error), 64'd0);
        check("uflow_flush_cnt", 64'(popped_count), 64'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 10; i++) begin
            push_data = 32'h200 + 32'(i);
            push_valid = 1'b1;
            step();
        end
        push_valid = 1'b0;
        check("mid_level", 64'(level), 64'd10);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(data_valid), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        check("arst_ready", 64'(push_ready), 64'd1);
        check("arst_data", 64'(data), 64'd0);
        resetn = 1'b1;
        push_data = 32'h1;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        check("post_rst_valid", 64'(data_valid), 64'd1);
        check("post_rst_data", 64'(data), 64'd1);
        check("post_rst_level", 64'(level), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
